// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch front end: owns the PC, the instruction-memory handshake and
// the IF/ID register, absorbing hazard holds, redirects and variable memory latency.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PC_write,
  input  logic                 IF_ID_write,
  input  logic                 redirect,
  input  logic [31:0]          redirect_target,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          PC_IF_ID,
  output logic [31:0]          Inst_IF_ID,
  output logic                 valid_IF_ID,
  output logic [CNT_WIDTH-1:0] starve_count
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    BUF     = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;

  logic [31:0] target;
  logic [31:0] pc_inc;
  logic        both_write;
  logic        deliver;
  logic [31:0] deliver_pc;
  logic [31:0] deliver_inst;
  logic        starve_event;
  logic        unused_target_lsbs;

  assign target             = {redirect_target[31:2], 2'b00};
  assign unused_target_lsbs = ^redirect_target[1:0];
  assign pc_inc             = pc + 32'd4;
  assign both_write         = PC_write && IF_ID_write;
  assign imem_addr          = req_addr;

  // Which instruction (if any) reaches IF/ID at the coming edge.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    deliver      = 1'b0;
    deliver_pc   = pc;
    deliver_inst = imem_rdata;
    case (state)
      FETCH: begin
        if (!redirect && imem_ack && both_write) deliver = 1'b1;
      end
      BUF: begin
        if (!redirect && both_write) begin
          deliver      = 1'b1;
          deliver_pc   = buf_pc;
          deliver_inst = buf_inst;
        end
      end
      default: ;
    endcase
  end

  // The BOOT bubble is a reset artefact and redirect bubbles are branch
  // penalty; neither is memory/hold starvation.
  assign starve_event = IF_ID_write && !deliver && !redirect && (state != BOOT);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      req_addr     <= RESET_PC;
      imem_req     <= 1'b0;
      buf_inst     <= '0;
      buf_pc       <= '0;
      PC_IF_ID     <= '0;
      Inst_IF_ID   <= '0;
      valid_IF_ID  <= 1'b0;
      starve_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (redirect) begin
            pc <= target;
            if (imem_ack) begin
              req_addr <= target;
            end else begin
              // The in-flight request must still complete before re-issuing.
              state <= DISCARD;
            end
          end else if (imem_ack) begin
            if (both_write) begin
              pc       <= pc_inc;
              req_addr <= pc_inc;
            end else begin
              buf_inst <= imem_rdata;
              buf_pc   <= pc;
              state    <= BUF;
              imem_req <= 1'b0;
            end
          end
        end
        BUF: begin
          if (redirect) begin
            pc       <= target;
            req_addr <= target;
            state    <= FETCH;
            imem_req <= 1'b1;
          end else if (both_write) begin
            pc       <= pc_inc;
            req_addr <= pc_inc;
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        DISCARD: begin
          if (redirect) pc <= target;
          if (imem_ack) begin
            req_addr <= redirect ? target : pc;
            state    <= FETCH;
          end
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase

      if (IF_ID_write) begin
        valid_IF_ID <= deliver;
        if (deliver) begin
          PC_IF_ID   <= deliver_pc;
          Inst_IF_ID <= deliver_inst;
        end
      end

      if (starve_event && (starve_count != '1)) begin
        starve_count <= starve_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // Memory relies on the address staying put until it acknowledges.
  addr_stable: assert property (@(posedge clk) disable iff (!rst)
    (imem_req && !imem_ack) |=> (imem_req && imem_addr == $past(imem_addr)));

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: transaction-level fetch model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_stage_ctrl;

  localparam int          CW         = 6;
  localparam logic [31:0] STARVE_MAX = 32'd63;

  logic          clk;
  logic          rst;
  logic          PC_write;
  logic          IF_ID_write;
  logic          redirect;
  logic [31:0]   redirect_target;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic [31:0]   PC_IF_ID;
  logic [31:0]   Inst_IF_ID;
  logic          valid_IF_ID;
  logic [CW-1:0] starve_count;

  int n_checks = 0;
  int n_errors = 0;
  int lat      = 0;
  int mem_wait;

  fetch_stage_ctrl #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .PC_write        (PC_write),
    .IF_ID_write     (IF_ID_write),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .PC_IF_ID        (PC_IF_ID),
    .Inst_IF_ID      (Inst_IF_ID),
    .valid_IF_ID     (valid_IF_ID),
    .starve_count    (starve_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A13;
  endfunction

  // Memory: acknowledges after 'lat' wait cycles of a continuous request.
  assign imem_ack   = imem_req && (mem_wait >= lat);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk or negedge rst) begin
    if (!rst)                      mem_wait <= 0;
    else if (imem_req && !imem_ack) mem_wait <= mem_wait + 1;
    else                           mem_wait <= 0;
  end

  // Reference model: what the front end is doing, in fetch terms.
  typedef struct packed {
    logic        booting;
    logic        holding;
    logic        stale;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] hold_pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic [31:0] starve;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r         = '0;
    r.booting = 1'b1;
    return r;
  endfunction

  function automatic model_t model_next(input model_t cur, input logic pw, input logic iw,
                                        input logic rd, input logic [31:0] tgt_raw,
                                        input logic ack);
    model_t      n;
    logic [31:0] tgt;
    logic        got;
    logic [31:0] got_pc;
    n      = cur;
    tgt    = {tgt_raw[31:2], 2'b00};
    got    = 1'b0;
    got_pc = '0;
    if (cur.booting) begin
      n.booting = 1'b0;
    end else if (cur.holding) begin
      if (rd) begin
        n.holding = 1'b0;
        n.pc      = tgt;
        n.addr    = tgt;
      end else if (pw && iw) begin
        got       = 1'b1;
        got_pc    = cur.hold_pc;
        n.holding = 1'b0;
        n.pc      = cur.pc + 32'd4;
        n.addr    = cur.pc + 32'd4;
      end
    end else if (cur.stale) begin
      if (rd) n.pc = tgt;
      if (ack) begin
        n.stale = 1'b0;
        n.addr  = n.pc;
      end
    end else if (rd) begin
      n.pc = tgt;
      if (ack) n.addr = tgt;
      else     n.stale = 1'b1;
    end else if (ack) begin
      if (pw && iw) begin
        got    = 1'b1;
        got_pc = cur.pc;
        n.pc   = cur.pc + 32'd4;
        n.addr = cur.pc + 32'd4;
      end else begin
        n.holding = 1'b1;
        n.hold_pc = cur.pc;
      end
    end
    if (iw) begin
      n.valid = got;
      if (got) begin
        n.ifid_pc   = got_pc;
        n.ifid_inst = mem_word(got_pc);
      end else if (!rd && !cur.booting && cur.starve != STARVE_MAX) begin
        n.starve = cur.starve + 32'd1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= model_reset();
    else      m <= model_next(m, PC_write, IF_ID_write, redirect, redirect_target, imem_ack);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic exp_req;
    exp_req = !m.booting && !m.holding;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, m.addr);
    check("PC_IF_ID", PC_IF_ID, m.ifid_pc);
    check("Inst_IF_ID", Inst_IF_ID, m.ifid_inst);
    check("valid_IF_ID", 32'(valid_IF_ID), 32'(m.valid));
    check("starve_count", 32'(starve_count), m.starve);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst             = 1'b0;
    PC_write        = 1'b1;
    IF_ID_write     = 1'b1;
    redirect        = 1'b0;
    redirect_target = '0;
    lat             = 0;

    #12;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(valid_IF_ID), 32'd0);
    check("rst_starve", 32'(starve_count), 32'd0);
    check("rst_pc_ifid", PC_IF_ID, 32'd0);
    cyc(1);
    rst = 1'b1;

    // Zero-wait streaming after reset release.
    cyc(1);
    check("boot_req", 32'(imem_req), 32'd1);
    check("boot_addr", imem_addr, 32'h0);
    check("boot_valid", 32'(valid_IF_ID), 32'd0);
    cyc(1);
    check("first_pc", PC_IF_ID, 32'h0);
    check("first_valid", 32'(valid_IF_ID), 32'd1);
    check("first_inst", Inst_IF_ID, 32'hC0DE_5A13);
    cyc(1);
    check("second_pc", PC_IF_ID, 32'h4);
    cyc(1);
    check("third_pc", PC_IF_ID, 32'h8);
    check("stream_starve", 32'(starve_count), 32'd0);

    // Two wait cycles per fetch.
    lat = 2;
    cyc(9);
    check("lat_pc", PC_IF_ID, 32'd20);
    check("lat_valid", 32'(valid_IF_ID), 32'd1);
    check("lat_starve", 32'(starve_count), 32'd6);

    // Ack lands during a hold: word buffered, IF/ID frozen.
    PC_write    = 1'b0;
    IF_ID_write = 1'b0;
    cyc(3);
    check("buf_req", 32'(imem_req), 32'd0);
    check("buf_frozen_pc", PC_IF_ID, 32'd20);
    check("buf_frozen_valid", 32'(valid_IF_ID), 32'd1);
    cyc(3);
    PC_write    = 1'b1;
    IF_ID_write = 1'b1;
    cyc(1);
    check("buf_release_pc", PC_IF_ID, 32'd24);
    check("buf_release_inst", Inst_IF_ID, 32'd24 ^ 32'hC0DE_5A13);
    check("buf_next_addr", imem_addr, 32'd28);
    check("buf_starve", 32'(starve_count), 32'd6);

    // Redirect while a request is outstanding.
    cyc(1);
    redirect        = 1'b1;
    redirect_target = 32'h0000_0103;
    cyc(1);
    redirect = 1'b0;
    check("disc_addr_held", imem_addr, 32'd28);
    check("disc_valid", 32'(valid_IF_ID), 32'd0);
    check("disc_starve", 32'(starve_count), 32'd7);
    cyc(1);
    check("disc_new_addr", imem_addr, 32'h0000_0100);
    check("disc_starve2", 32'(starve_count), 32'd8);
    lat = 0;
    cyc(1);
    check("disc_target_pc", PC_IF_ID, 32'h0000_0100);
    check("disc_target_valid", 32'(valid_IF_ID), 32'd1);

    // Redirect together with hold and ack: redirect wins, IF/ID untouched.
    PC_write        = 1'b0;
    IF_ID_write     = 1'b0;
    redirect        = 1'b1;
    redirect_target = 32'h0000_0200;
    cyc(1);
    check("prio_pc_ifid", PC_IF_ID, 32'h0000_0100);
    check("prio_valid", 32'(valid_IF_ID), 32'd1);
    check("prio_addr", imem_addr, 32'h0000_0200);
    PC_write    = 1'b1;
    IF_ID_write = 1'b1;
    redirect    = 1'b0;
    cyc(1);
    check("prio_target_pc", PC_IF_ID, 32'h0000_0200);

    // Plain redirect penalty: one bubble.
    redirect        = 1'b1;
    redirect_target = 32'h0000_0300;
    cyc(1);
    redirect = 1'b0;
    check("pen_bubble", 32'(valid_IF_ID), 32'd0);
    check("pen_starve", 32'(starve_count), 32'd8);
    cyc(1);
    check("pen_target", PC_IF_ID, 32'h0000_0300);

    // PC wrap-around.
    redirect        = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    cyc(1);
    redirect = 1'b0;
    cyc(1);
    check("wrap_pc", PC_IF_ID, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);
    cyc(1);
    check("wrap_next_pc", PC_IF_ID, 32'h0);

    // Mixed hold patterns with one-wait memory.
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      PC_write        = (i % 5) != 4;
      IF_ID_write     = (i % 7) != 3;
      redirect        = (i == 17);
      redirect_target = 32'h0000_0040;
      cyc(1);
    end
    PC_write    = 1'b1;
    IF_ID_write = 1'b1;
    redirect    = 1'b0;

    // Counter saturation.
    lat = 3;
    cyc(90);
    check("sat_starve", 32'(starve_count), 32'd63);
    cyc(10);
    check("sat_hold", 32'(starve_count), 32'd63);

    // Asynchronous reset in the middle of a request.
    cyc(1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_pc", PC_IF_ID, 32'h0);
    check("mid_rst_inst", Inst_IF_ID, 32'h0);
    check("mid_rst_valid", 32'(valid_IF_ID), 32'd0);
    check("mid_rst_starve", 32'(starve_count), 32'd0);
    cyc(2);
    rst = 1'b1;
    lat = 0;
    cyc(3);
    check("restart_pc", PC_IF_ID, 32'h4);
    check("restart_valid", 32'(valid_IF_ID), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
